// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared constants, slot index type and the BCD to 7-segment
//                decoder used by the stopwatch display reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [7:0] SSEG_BLANK = 8'hFF;
    localparam logic [6:0] SSEG_DASH  = 7'b0111111;

    typedef logic [2:0] slot_t;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash
    function automatic logic [6:0] bcd_to_sseg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SSEG_DASH;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_m_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_m_counter
//  Description : Free-running modulo-M counter with a terminal-count tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_m_counter #(
    parameter int  M = 4,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         clr,
    output logic         tick,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_LAST = W'(M - 1);

    logic [W-1:0] r_count;

    // Count 0..M-1 and wrap
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;
    assign tick  = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/stopwatch_disp.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_disp
//  Description : Samples the six stopwatch BCD digits once per scan frame and
//                drives a multiplexed active-low 7-segment display (MM.SS.cc)
//                with optional leading-zero blanking and a lap hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_disp
    import stopwatch_pkg::*;
#(
    parameter int DVSR = 100_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d5,
    input  logic [3:0] d4,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       hold,
    input  logic       blank_lz,
    output logic [7:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int    c_CW        = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam slot_t c_LAST_SLOT = slot_t'(NUM_DIGITS - 1);

    logic            w_tick;
    logic [c_CW-1:0] w_cnt;
    logic            w_wrap;
    logic [3:0]      w_din  [NUM_DIGITS];
    logic [3:0]      w_digit;
    logic            w_blank;
    logic            w_dp;
    logic [7:0]      w_sseg;
    logic [7:0]      w_an;
    logic            w_frame_start;

    slot_t           r_slot;
    logic [3:0]      r_snap [NUM_DIGITS];
    logic            r_framed;
    logic [7:0]      r_an;
    logic [7:0]      r_sseg;
    logic            r_frame_tick;

    mod_m_counter #(
        .M     (DVSR)
    ) u_slot_rate (
        .clk   (clk),
        .clr   (clr),
        .tick  (w_tick),
        .count (w_cnt)
    );

    assign w_wrap = w_tick && (r_slot == c_LAST_SLOT);

    // Gather the digit bus into slot order
    always_comb begin
        w_din[0] = d0;
        w_din[1] = d1;
        w_din[2] = d2;
        w_din[3] = d3;
        w_din[4] = d4;
        w_din[5] = d5;
    end

    // Advance the display slot once per slot period
    always_ff @(posedge clk) begin
        if (clr) begin
            r_slot <= '0;
        end else if (w_tick) begin
            r_slot <= (r_slot == c_LAST_SLOT) ? slot_t'(0) : r_slot + slot_t'(1);
        end
    end

    // Snapshot digits at each frame wrap unless a lap hold is active;
    // r_framed marks that at least one full frame has started since reset
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_snap[i] <= '0;
            end
            r_framed <= 1'b0;
        end else if (w_wrap) begin
            if (!hold) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_snap[i] <= w_din[i];
                end
            end
            r_framed <= 1'b1;
        end
    end

    // Select the snapshot digit for the current slot and build its pattern
    always_comb begin
        w_digit = 4'h0;
        case (r_slot)
            3'd0:    w_digit = r_snap[0];
            3'd1:    w_digit = r_snap[1];
            3'd2:    w_digit = r_snap[2];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[4];
            3'd5:    w_digit = r_snap[5];
            default: w_digit = 4'h0;
        endcase
        // Decimal points sit after the minutes and seconds pairs
        w_dp    = !((r_slot == 3'd2) || (r_slot == 3'd4));
        w_blank = blank_lz &&
                  (((r_slot == 3'd5) && (r_snap[5] == 4'h0)) ||
                   ((r_slot == 3'd4) && (r_snap[5] == 4'h0) && (r_snap[4] == 4'h0)));
        w_sseg  = w_blank ? SSEG_BLANK : {w_dp, bcd_to_sseg(w_digit)};
        w_an    = ~(8'h01 << r_slot);
        w_frame_start = r_framed && (r_slot == 3'd0) && (w_cnt == '0);
    end

    // Register display outputs; reset forces everything off
    always_ff @(posedge clk) begin
        if (clr) begin
            r_an         <= 8'hFF;
            r_sseg       <= SSEG_BLANK;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_sseg       <= w_sseg;
            r_frame_tick <= w_frame_start;
        end
    end

    assign an         = r_an;
    assign sseg       = r_sseg;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_disp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_disp
//  Description : Directed self-checking bench for stopwatch_disp (DVSR = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_disp;

    logic       clk;
    logic       clr;
    logic [3:0] d5, d4, d3, d2, d1, d0;
    logic       hold;
    logic       blank_lz;
    logic [7:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    int checks;
    int errors;
    int oc;     // output cycle index since the last reset release

    stopwatch_disp #(
        .DVSR       (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .d5         (d5),
        .d4         (d4),
        .d3         (d3),
        .d2         (d2),
        .d1         (d1),
        .d0         (d0),
        .hold       (hold),
        .blank_lz   (blank_lz),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        oc++;
    endtask

    task automatic advance_to(input int target);
        while (oc < target) step();
    endtask

    task automatic set_digits(input logic [3:0] v5, v4, v3, v2, v1, v0);
        d5 = v5; d4 = v4; d3 = v3; d2 = v2; d1 = v1; d0 = v0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        oc = 0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (an !== 8'hFF || sseg !== 8'hFF || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: an=%h sseg=%h ft=%b, want an=ff sseg=ff ft=0", i, an, sseg, frame_tick);
            end
        end
        clr = 1'b0;
        step();
        oc = 0;
        checks++;
        if (an !== 8'hFE || sseg !== 8'hC0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: an=%h sseg=%h ft=%b, want an=fe sseg=c0 ft=0", an, sseg, frame_tick);
        end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (an !== 8'hFE) begin
                errors++;
                $display("FAIL slot0_len[%0d]: an=%h, want fe", i, an);
            end
        end
        step();
        checks++;
        if (an !== 8'hFD || sseg !== 8'hC0) begin
            errors++;
            $display("FAIL slot1_start: an=%h sseg=%h, want an=fd sseg=c0", an, sseg);
        end
    endtask

    task automatic test_snapshot_latency();
        set_digits(4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9);
        do_reset();
        advance_to(8);
        checks++;
        if (an !== 8'hFB || sseg !== 8'h40) begin
            errors++;
            $display("FAIL snap_first_slot2: an=%h sseg=%h, want an=fb sseg=40", an, sseg);
        end
        advance_to(20);
        checks++;
        if (an !== 8'hDF || sseg !== 8'hC0) begin
            errors++;
            $display("FAIL snap_first_slot5: an=%h sseg=%h, want an=df sseg=c0", an, sseg);
        end
        advance_to(23);
        checks++;
        if (frame_tick !== 1'b0 || sseg !== 8'hC0) begin
            errors++;
            $display("FAIL snap_pre_wrap: ft=%b sseg=%h, want ft=0 sseg=c0", frame_tick, sseg);
        end
        step();
        checks++;
        if (frame_tick !== 1'b1 || an !== 8'hFE || sseg !== 8'h90) begin
            errors++;
            $display("FAIL snap_wrap_slot0: ft=%b an=%h sseg=%h, want ft=1 an=fe sseg=90", frame_tick, an, sseg);
        end
        step();
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL snap_tick_width: ft=%b, want 0", frame_tick);
        end
        advance_to(32);
        checks++;
        if (an !== 8'hFB || sseg !== 8'h10) begin
            errors++;
            $display("FAIL snap_slot2: an=%h sseg=%h, want an=fb sseg=10", an, sseg);
        end
        advance_to(44);
        checks++;
        if (an !== 8'hDF || sseg !== 8'h92) begin
            errors++;
            $display("FAIL snap_slot5: an=%h sseg=%h, want an=df sseg=92", an, sseg);
        end
    endtask

    task automatic test_hold();
        set_digits(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        do_reset();
        advance_to(24);
        checks++;
        if (an !== 8'hFE || sseg !== 8'h92) begin
            errors++;
            $display("FAIL hold_loaded: an=%h sseg=%h, want an=fe sseg=92", an, sseg);
        end
        hold = 1'b1;
        set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        advance_to(48);
        checks++;
        if (frame_tick !== 1'b1 || sseg !== 8'h92) begin
            errors++;
            $display("FAIL hold_frame1: ft=%b sseg=%h, want ft=1 sseg=92", frame_tick, sseg);
        end
        advance_to(68);
        checks++;
        if (an !== 8'hDF || sseg !== 8'hC0) begin
            errors++;
            $display("FAIL hold_slot5: an=%h sseg=%h, want an=df sseg=c0", an, sseg);
        end
        advance_to(72);
        checks++;
        if (sseg !== 8'h92) begin
            errors++;
            $display("FAIL hold_frame2: sseg=%h, want 92", sseg);
        end
        hold = 1'b0;
        advance_to(96);
        checks++;
        if (an !== 8'hFE || sseg !== 8'h90) begin
            errors++;
            $display("FAIL hold_release: an=%h sseg=%h, want an=fe sseg=90", an, sseg);
        end
        advance_to(112);
        checks++;
        if (an !== 8'hEF || sseg !== 8'h10) begin
            errors++;
            $display("FAIL hold_release_slot4: an=%h sseg=%h, want an=ef sseg=10", an, sseg);
        end
    endtask

    task automatic test_blanking();
        blank_lz = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'd4, 4'd2);
        do_reset();
        advance_to(32);
        checks++;
        if (an !== 8'hFB || sseg !== 8'h78) begin
            errors++;
            $display("FAIL blank_slot2: an=%h sseg=%h, want an=fb sseg=78", an, sseg);
        end
        advance_to(36);
        checks++;
        if (an !== 8'hF7 || sseg !== 8'hC0) begin
            errors++;
            $display("FAIL blank_slot3: an=%h sseg=%h, want an=f7 sseg=c0", an, sseg);
        end
        advance_to(40);
        checks++;
        if (an !== 8'hEF || sseg !== 8'hFF) begin
            errors++;
            $display("FAIL blank_slot4: an=%h sseg=%h, want an=ef sseg=ff", an, sseg);
        end
        advance_to(44);
        checks++;
        if (an !== 8'hDF || sseg !== 8'hFF) begin
            errors++;
            $display("FAIL blank_slot5: an=%h sseg=%h, want an=df sseg=ff", an, sseg);
        end
        blank_lz = 1'b0;
        advance_to(64);
        checks++;
        if (an !== 8'hEF || sseg !== 8'h40) begin
            errors++;
            $display("FAIL noblank_slot4: an=%h sseg=%h, want an=ef sseg=40", an, sseg);
        end
    endtask

    task automatic test_invalid_bcd();
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'hC, 4'd0);
        do_reset();
        advance_to(28);
        checks++;
        if (an !== 8'hFD || sseg !== 8'hBF) begin
            errors++;
            $display("FAIL invalid_bcd: an=%h sseg=%h, want an=fd sseg=bf", an, sseg);
        end
    endtask

    task automatic test_midframe_reset();
        set_digits(4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9);
        do_reset();
        advance_to(36);
        clr = 1'b1;
        step();
        checks++;
        if (an !== 8'hFF || sseg !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_clr_off: an=%h sseg=%h ft=%b, want an=ff sseg=ff ft=0", an, sseg, frame_tick);
        end
        clr = 1'b0;
        step();
        oc = 0;
        checks++;
        if (an !== 8'hFE || sseg !== 8'hC0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_clr_restart: an=%h sseg=%h ft=%b, want an=fe sseg=c0 ft=0", an, sseg, frame_tick);
        end
        while (oc < 23) begin
            step();
            checks++;
            if (frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL mid_clr_no_tick[%0d]: ft=%b, want 0", oc, frame_tick);
            end
        end
        step();
        checks++;
        if (frame_tick !== 1'b1 || an !== 8'hFE || sseg !== 8'h90) begin
            errors++;
            $display("FAIL mid_clr_next_frame: ft=%b an=%h sseg=%h, want ft=1 an=fe sseg=90", frame_tick, an, sseg);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        oc       = 0;
        clr      = 1'b1;
        hold     = 1'b0;
        blank_lz = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        test_reset();
        test_snapshot_latency();
        test_hold();
        test_blanking();
        test_invalid_bcd();
        test_midframe_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
